// File: rtl/gb_cpu_decoder.sv
// SM83 instruction decoder: classifies opcode / CB-prefixed opcode / interrupt dispatch
// into an execution schedule (class, M-cycle counts, condition, operand fields), registered.
module gb_cpu_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  opcode,
  input  logic        cb_prefix,
  input  logic        isr_cmd,
  output logic [23:0] schedule
);

  typedef struct packed {
    logic [5:0] op_class;
    logic [3:0] m_cycles;
    logic [3:0] m_cycles_nt;
    logic       cond_en;
    logic [1:0] cond;
    logic [2:0] reg_a;
    logic [2:0] reg_b;
    logic       hl_mem;
  } schedule_t;

  localparam logic [5:0] C_NOP         = 6'd0;
  localparam logic [5:0] C_JP_HL       = 6'd1;
  localparam logic [5:0] C_JP          = 6'd2;
  localparam logic [5:0] C_JP_CC       = 6'd3;
  localparam logic [5:0] C_JR          = 6'd4;
  localparam logic [5:0] C_JR_CC       = 6'd5;
  localparam logic [5:0] C_CALL        = 6'd6;
  localparam logic [5:0] C_CALL_CC     = 6'd7;
  localparam logic [5:0] C_RET         = 6'd8;
  localparam logic [5:0] C_RET_CC      = 6'd9;
  localparam logic [5:0] C_RETI        = 6'd10;
  localparam logic [5:0] C_RST         = 6'd11;
  localparam logic [5:0] C_ISR         = 6'd12;
  localparam logic [5:0] C_HALT        = 6'd13;
  localparam logic [5:0] C_STOP        = 6'd14;
  localparam logic [5:0] C_DI          = 6'd15;
  localparam logic [5:0] C_EI          = 6'd16;
  localparam logic [5:0] C_PREFIX      = 6'd17;
  localparam logic [5:0] C_ROT_A       = 6'd18;
  localparam logic [5:0] C_LD_R_R      = 6'd19;
  localparam logic [5:0] C_LD_R_HLM    = 6'd20;
  localparam logic [5:0] C_LD_HLM_R    = 6'd21;
  localparam logic [5:0] C_LD_R_N      = 6'd22;
  localparam logic [5:0] C_LD_HLM_N    = 6'd23;
  localparam logic [5:0] C_LD_RR_NN    = 6'd24;
  localparam logic [5:0] C_LD_A_RRM    = 6'd25;
  localparam logic [5:0] C_LD_RRM_A    = 6'd26;
  localparam logic [5:0] C_LDH_N_A     = 6'd27;
  localparam logic [5:0] C_LDH_A_N     = 6'd28;
  localparam logic [5:0] C_LDH_C_A     = 6'd29;
  localparam logic [5:0] C_LDH_A_C     = 6'd30;
  localparam logic [5:0] C_LD_NN_A     = 6'd31;
  localparam logic [5:0] C_LD_A_NN     = 6'd32;
  localparam logic [5:0] C_LD_NN_SP    = 6'd33;
  localparam logic [5:0] C_PUSH        = 6'd34;
  localparam logic [5:0] C_POP         = 6'd35;
  localparam logic [5:0] C_LD_HL_SPE   = 6'd36;
  localparam logic [5:0] C_LD_SP_HL    = 6'd37;
  localparam logic [5:0] C_ADD_SP_E    = 6'd38;
  localparam logic [5:0] C_ALU_R       = 6'd39;
  localparam logic [5:0] C_ALU_HLM     = 6'd40;
  localparam logic [5:0] C_ALU_N       = 6'd41;
  localparam logic [5:0] C_INC_DEC_R   = 6'd42;
  localparam logic [5:0] C_INC_DEC_HLM = 6'd43;
  localparam logic [5:0] C_INC_DEC_RR  = 6'd44;
  localparam logic [5:0] C_ADD_HL_RR   = 6'd45;
  localparam logic [5:0] C_CB_R        = 6'd46;
  localparam logic [5:0] C_CB_HLM      = 6'd47;
  localparam logic [5:0] C_BIT_HLM     = 6'd48;
  localparam logic [5:0] C_MISC_ACC    = 6'd49;
  localparam logic [5:0] C_ILLEGAL     = 6'd63;

  logic [1:0] x;
  logic [2:0] y;
  logic [2:0] z;
  logic       q;
  assign x = opcode[7:6];
  assign y = opcode[5:3];
  assign z = opcode[2:0];
  assign q = opcode[3];

  logic [5:0] cls;
  logic [3:0] mc;
  logic [3:0] mc_nt;
  logic       cc_en;
  logic       hl;
  schedule_t  sched_next;
  schedule_t  sched_reg;

  // Opcode map walked by x/y/z octal fields, the usual SM83 decoding structure.
  always_comb begin
    cls = C_NOP;
    if (isr_cmd) begin
      cls = C_ISR;
    end else if (cb_prefix) begin
      if (z == 3'd6) cls = (x == 2'd1) ? C_BIT_HLM : C_CB_HLM;
      else           cls = C_CB_R;
    end else begin
      case (x)
        2'd0: begin
          case (z)
            3'd0: begin
              case (y)
                3'd0:    cls = C_NOP;
                3'd1:    cls = C_LD_NN_SP;
                3'd2:    cls = C_STOP;
                3'd3:    cls = C_JR;
                default: cls = C_JR_CC;
              endcase
            end
            3'd1: cls = q ? C_ADD_HL_RR : C_LD_RR_NN;
            3'd2: cls = q ? C_LD_A_RRM : C_LD_RRM_A;
            3'd3: cls = C_INC_DEC_RR;
            3'd4, 3'd5: cls = (y == 3'd6) ? C_INC_DEC_HLM : C_INC_DEC_R;
            3'd6: cls = (y == 3'd6) ? C_LD_HLM_N : C_LD_R_N;
            default: cls = y[2] ? C_MISC_ACC : C_ROT_A;
          endcase
        end
        2'd1: begin
          if (opcode == 8'h76)  cls = C_HALT;
          else if (z == 3'd6)   cls = C_LD_R_HLM;
          else if (y == 3'd6)   cls = C_LD_HLM_R;
          else                  cls = C_LD_R_R;
        end
        2'd2: cls = (z == 3'd6) ? C_ALU_HLM : C_ALU_R;
        default: begin
          case (z)
            3'd0: begin
              case (y)
                3'd4:    cls = C_LDH_N_A;
                3'd5:    cls = C_ADD_SP_E;
                3'd6:    cls = C_LDH_A_N;
                3'd7:    cls = C_LD_HL_SPE;
                default: cls = C_RET_CC;
              endcase
            end
            3'd1: begin
              case (y)
                3'd1:    cls = C_RET;
                3'd3:    cls = C_RETI;
                3'd5:    cls = C_JP_HL;
                3'd7:    cls = C_LD_SP_HL;
                default: cls = C_POP;
              endcase
            end
            3'd2: begin
              case (y)
                3'd4:    cls = C_LDH_C_A;
                3'd5:    cls = C_LD_NN_A;
                3'd6:    cls = C_LDH_A_C;
                3'd7:    cls = C_LD_A_NN;
                default: cls = C_JP_CC;
              endcase
            end
            3'd3: begin
              case (y)
                3'd0:    cls = C_JP;
                3'd1:    cls = C_PREFIX;
                3'd6:    cls = C_DI;
                3'd7:    cls = C_EI;
                default: cls = C_ILLEGAL;
              endcase
            end
            3'd4: cls = y[2] ? C_ILLEGAL : C_CALL_CC;
            3'd5: begin
              case (y)
                3'd1:              cls = C_CALL;
                3'd3, 3'd5, 3'd7:  cls = C_ILLEGAL;
                default:           cls = C_PUSH;
              endcase
            end
            3'd6: cls = C_ALU_N;
            default: cls = C_RST;
          endcase
        end
      endcase
    end
  end

  // Per-class timing; mc_nt only differs from mc for the conditional branches.
  always_comb begin
    mc    = 4'd1;
    cc_en = 1'b0;
    case (cls)
      C_JP, C_RET, C_RETI, C_RST, C_LD_NN_A, C_LD_A_NN,
      C_PUSH, C_ADD_SP_E, C_CB_HLM, C_JP_CC:                  mc = 4'd4;
      C_JR, C_LD_HLM_N, C_LD_RR_NN, C_LDH_N_A, C_LDH_A_N,
      C_POP, C_LD_HL_SPE, C_INC_DEC_HLM, C_BIT_HLM, C_JR_CC:  mc = 4'd3;
      C_CALL, C_CALL_CC:                                      mc = 4'd6;
      C_ISR, C_LD_NN_SP, C_RET_CC:                            mc = 4'd5;
      C_LD_R_HLM, C_LD_HLM_R, C_LD_R_N, C_LD_A_RRM, C_LD_RRM_A,
      C_LDH_C_A, C_LDH_A_C, C_LD_SP_HL, C_ALU_HLM, C_ALU_N,
      C_INC_DEC_RR, C_ADD_HL_RR, C_CB_R:                      mc = 4'd2;
      default:                                                mc = 4'd1;
    endcase
    mc_nt = mc;
    case (cls)
      C_JP_CC, C_CALL_CC: begin cc_en = 1'b1; mc_nt = 4'd3; end
      C_JR_CC, C_RET_CC:  begin cc_en = 1'b1; mc_nt = 4'd2; end
      default: ;
    endcase
  end

  always_comb begin
    case (cls)
      C_LD_R_HLM, C_LD_HLM_R, C_LD_HLM_N, C_ALU_HLM,
      C_INC_DEC_HLM, C_CB_HLM, C_BIT_HLM: hl = 1'b1;
      default:                            hl = 1'b0;
    endcase
  end

  always_comb begin
    sched_next.op_class    = cls;
    sched_next.m_cycles    = mc;
    sched_next.m_cycles_nt = mc_nt;
    sched_next.cond_en     = cc_en;
    sched_next.cond        = cc_en ? opcode[4:3] : 2'd0;
    sched_next.reg_a       = isr_cmd ? 3'd0 : opcode[5:3];
    sched_next.reg_b       = isr_cmd ? 3'd0 : opcode[2:0];
    sched_next.hl_mem      = hl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sched_reg <= '0;
    else        sched_reg <= sched_next;
  end

  assign schedule = sched_reg;

endmodule

// File: tb/tb_gb_cpu_decoder.sv
// Self-checking bench for gb_cpu_decoder: directed decode cases, priority, reset and
// a full unprefixed sweep for ILLEGAL classification, scored through an expectation queue.
module tb_gb_cpu_decoder;

  logic        clk;
  logic        rst_n;
  logic [7:0]  opcode;
  logic        cb_prefix;
  logic        isr_cmd;
  logic [23:0] schedule;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        full;   // 1: compare whole word, 0: compare only ILLEGAL-ness
    logic [23:0] exp;
    logic [7:0]  op;
    logic        cb;
    logic        isr;
  } sb_item_t;

  sb_item_t sb[$];

  gb_cpu_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .cb_prefix (cb_prefix),
    .isr_cmd   (isr_cmd),
    .schedule  (schedule)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] mk(input int cls, input int mc, input int nt, input bit ce,
                                     input logic [7:0] op, input bit hl);
    logic [5:0] c6;
    logic [3:0] m4;
    logic [3:0] n4;
    c6 = cls[5:0];
    m4 = mc[3:0];
    n4 = nt[3:0];
    return {c6, m4, n4, ce, (ce ? op[4:3] : 2'b00), op[5:3], op[2:0], hl};
  endfunction

  task automatic drive(input logic [7:0] op, input logic cb, input logic isr,
                       input logic full, input logic [23:0] exp);
    sb_item_t it;
    @(negedge clk);
    opcode    = op;
    cb_prefix = cb;
    isr_cmd   = isr;
    it.full = full; it.exp = exp; it.op = op; it.cb = cb; it.isr = isr;
    sb.push_back(it);
  endtask

  task automatic test_reset;
    sb_item_t e;
    rst_n = 1'b1; opcode = 8'h00; cb_prefix = 1'b0; isr_cmd = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (schedule !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_async: got %h want 000000", schedule);
    end
    opcode = 8'hC3;
    @(posedge clk); #1;
    n_checks++;
    if (schedule !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want 000000", schedule);
    end
    @(negedge clk); rst_n = 1'b1;
    drive(8'hC3, 1'b0, 1'b0, 1'b1, mk(2, 4, 4, 0, 8'hC3, 0));
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (schedule !== e.exp) begin
      n_fail++;
      $display("FAIL reset_release_c3: got %h want %h", schedule, e.exp);
    end
    // Assert reset mid-cycle: output must clear with no clock edge in between.
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (schedule !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_midcycle: got %h want 000000", schedule);
    end
    @(negedge clk); rst_n = 1'b1;
    drive(8'hE9, 1'b0, 1'b0, 1'b1, mk(1, 1, 1, 0, 8'hE9, 0));
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (schedule !== e.exp) begin
      n_fail++;
      $display("FAIL reset_then_e9: got %h want %h", schedule, e.exp);
    end
    $display("reset: sequence done, schedule=%h", schedule);
  endtask

  task automatic test_control_flow;
    logic [7:0]  ops [9] = '{8'hC3, 8'hC2, 8'h20, 8'hC4, 8'hC0, 8'hD9, 8'hC7, 8'hD8, 8'hC9};
    logic [23:0] exps[9];
    sb_item_t e;
    exps[0] = mk(2,  4, 4, 0, 8'hC3, 0);
    exps[1] = mk(3,  4, 3, 1, 8'hC2, 0);
    exps[2] = mk(5,  3, 2, 1, 8'h20, 0);
    exps[3] = mk(7,  6, 3, 1, 8'hC4, 0);
    exps[4] = mk(9,  5, 2, 1, 8'hC0, 0);
    exps[5] = mk(10, 4, 4, 0, 8'hD9, 0);
    exps[6] = mk(11, 4, 4, 0, 8'hC7, 0);
    exps[7] = mk(9,  5, 2, 1, 8'hD8, 0);
    exps[8] = mk(8,  4, 4, 0, 8'hC9, 0);
    for (int i = 0; i < 9; i++) begin
      drive(ops[i], 1'b0, 1'b0, 1'b1, exps[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (schedule !== e.exp) begin
        n_fail++;
        $display("FAIL ctrl_%h: got %h want %h", e.op, schedule, e.exp);
      end else $display("ctrl op=%h schedule=%h ok", e.op, schedule);
    end
  endtask

  task automatic test_priority_cb;
    logic [7:0]  ops [6] = '{8'hC3, 8'h46, 8'h00, 8'h06, 8'h37, 8'hFE};
    logic        cbs [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        isrs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [23:0] exps[6];
    sb_item_t e;
    exps[0] = mk(12, 5, 5, 0, 8'h00, 0);
    exps[1] = mk(48, 3, 3, 0, 8'h46, 1);
    exps[2] = mk(46, 2, 2, 0, 8'h00, 0);
    exps[3] = mk(47, 4, 4, 0, 8'h06, 1);
    exps[4] = mk(46, 2, 2, 0, 8'h37, 0);
    exps[5] = mk(47, 4, 4, 0, 8'hFE, 1);
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], cbs[i], isrs[i], 1'b1, exps[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (schedule !== e.exp) begin
        n_fail++;
        $display("FAIL prio_cb_%h_isr%0d: got %h want %h", e.op, e.isr, schedule, e.exp);
      end else $display("prio/cb op=%h isr=%0d schedule=%h ok", e.op, e.isr, schedule);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  ops [7] = '{8'h76, 8'h4E, 8'h36, 8'hAB, 8'h08, 8'h70, 8'hE8};
    logic [23:0] exps[7];
    sb_item_t e;
    exps[0] = mk(13, 1, 1, 0, 8'h76, 0);
    exps[1] = mk(20, 2, 2, 0, 8'h4E, 1);
    exps[2] = mk(23, 3, 3, 0, 8'h36, 1);
    exps[3] = mk(39, 1, 1, 0, 8'hAB, 0);
    exps[4] = mk(33, 5, 5, 0, 8'h08, 0);
    exps[5] = mk(21, 2, 2, 0, 8'h70, 1);
    exps[6] = mk(38, 4, 4, 0, 8'hE8, 0);
    for (int i = 0; i < 7; i++) begin
      drive(ops[i], 1'b0, 1'b0, 1'b1, exps[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (schedule !== e.exp) begin
        n_fail++;
        $display("FAIL ldalu_%h: got %h want %h", e.op, schedule, e.exp);
      end else $display("ld/alu op=%h schedule=%h ok", e.op, schedule);
    end
  endtask

  task automatic test_sweep;
    logic [7:0] ill [11] = '{8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
                             8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD};
    logic [23:0] prev;
    logic        is_ill;
    logic        got_ill;
    logic [7:0]  op;
    sb_item_t    e;
    int          sweep_fail;
    sweep_fail = n_fail;
    for (int i = 0; i < 256; i++) begin
      op = i[7:0];
      is_ill = 1'b0;
      for (int k = 0; k < 11; k++) if (ill[k] == op) is_ill = 1'b1;
      @(negedge clk);
      prev = schedule;
      opcode = op; cb_prefix = 1'b0; isr_cmd = 1'b0;
      e.full = 1'b0; e.exp = {23'd0, is_ill}; e.op = op; e.cb = 1'b0; e.isr = 1'b0;
      sb.push_back(e);
      #1;
      n_checks++;
      if (schedule !== prev) begin
        n_fail++;
        $display("FAIL no_edge_update_%h: got %h want %h", op, schedule, prev);
      end
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sweep_queue_empty: got 0 entries want 1");
      end else begin
        e = sb.pop_front();
        got_ill = (schedule[23:18] == 6'd63);
        n_checks++;
        if (got_ill !== e.exp[0]) begin
          n_fail++;
          $display("FAIL sweep_illegal_%h: got class %0d want illegal=%0d", e.op, schedule[23:18], e.exp[0]);
        end
      end
    end
    $display("sweep: 256 opcodes, %0d new failures", n_fail - sweep_fail);
  endtask

  initial begin
    test_reset();
    test_control_flow();
    test_priority_cb();
    test_back_to_back();
    test_sweep();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
